// File: rtl/iob_target_pkg.sv
// Shared types and helpers for the IOB target: FSM states, window kinds,
// register indices and the E-clock edge detector.
package iob_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT,
    ST_ACK,
    ST_VWAIT,
    ST_VXFER,
    ST_ERR,
    ST_HOLD,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    WIN_MBX,
    WIN_VPA,
    WIN_BERR,
    WIN_IGNORE
  } win_t;

  localparam logic [2:0] REG_ID    = 3'd0;
  localparam logic [2:0] REG_DBELL = 3'd7;
  localparam int         NUM_WORDS = 8;

  // rising=1 detects 0->1 between two consecutive samples, rising=0 detects 1->0
  function automatic logic e_edge(input logic prev, input logic cur, input logic rising);
    return rising ? (!prev && cur) : (prev && !cur);
  endfunction

  function automatic win_t decode_window(input logic [23:1] addr,
                                         input logic [15:0] base,
                                         input logic [15:0] vbase);
    if (addr[23:8] == base)
      return (addr[7:1] < 7'd8) ? WIN_MBX : WIN_BERR;
    else if (addr[23:8] == vbase)
      return WIN_VPA;
    else
      return WIN_IGNORE;
  endfunction

endpackage

// File: rtl/iob_target_regs.sv
// Mailbox register file: word 0 is a fixed ID, words 1-6 are byte-writable,
// word 7 reflects the doorbell IRQ, which local-side clear overrides.
module iob_target_regs
  import iob_target_pkg::*;
#(
  parameter logic [15:0] ID_WORD = 16'h5E30
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [2:0]  addr,
  input  logic        wr_en,
  input  logic [1:0]  lane_en,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  input  logic        bell_set,
  input  logic        irq_clr,
  output logic        irq
);

  logic [NUM_WORDS-1:0][15:0] words;
  logic                       irq_reg;

  assign words[REG_ID]    = ID_WORD;
  assign words[REG_DBELL] = {15'b0, irq_reg};

  generate
    for (genvar gi = 1; gi < NUM_WORDS - 1; gi++) begin : g_word
      logic [15:0] word_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          word_reg <= '0;
        end else if (wr_en && addr == 3'(gi)) begin
          if (lane_en[1]) word_reg[15:8] <= wr_data[15:8];
          if (lane_en[0]) word_reg[7:0]  <= wr_data[7:0];
        end
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  assign rd_data = words[addr];

  always_ff @(posedge clk) begin
    if (srst)          irq_reg <= 1'b0;
    else if (irq_clr)  irq_reg <= 1'b0;
    else if (bell_set) irq_reg <= 1'b1;
  end

  assign irq = irq_reg;

endmodule

// File: rtl/iob_target.sv
// 68000-protocol IOB bus responder: nDTACK mailbox window, nVPA/E-clock
// doorbell window and nBERR for out-of-range mailbox offsets.
module iob_target
  import iob_target_pkg::*;
#(
  parameter logic [15:0] BASE        = 16'hF8F0,
  parameter logic [15:0] VBASE       = 16'hF8F1,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] ID_WORD     = 16'h5E30
) (
  input  logic        CLK_IOB,
  input  logic        RES,
  input  logic [23:1] A_IOB,
  input  logic        nAS_IOB,
  input  logic        nUDS_IOB,
  input  logic        nLDS_IOB,
  input  logic        nWE_IOB,
  input  logic        nVMA_IOB,
  input  logic        E_IOB,
  input  logic [15:0] DIN_IOB,
  output logic [15:0] DOUT_IOB,
  output logic        nDOE_IOB,
  output logic        nDTACK_IOB,
  output logic        nVPA_IOB,
  output logic        nBERR_IOB,
  output logic        IRQ,
  input  logic        IRQ_CLR
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  // Single registration stage; the initiator already runs on CLK_IOB.
  logic [23:1] a_s_reg;
  logic        nas_s_reg, nuds_s_reg, nlds_s_reg, nwe_s_reg, nvma_s_reg;
  logic        e_s_reg, e_prev_reg;
  logic [15:0] din_s_reg;

  always_ff @(posedge CLK_IOB) begin
    a_s_reg    <= A_IOB;
    nas_s_reg  <= nAS_IOB;
    nuds_s_reg <= nUDS_IOB;
    nlds_s_reg <= nLDS_IOB;
    nwe_s_reg  <= nWE_IOB;
    nvma_s_reg <= nVMA_IOB;
    e_s_reg    <= E_IOB;
    e_prev_reg <= e_s_reg;
    din_s_reg  <= DIN_IOB;
  end

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        ndtack_reg, ndtack_next;
  logic        nvpa_reg, nvpa_next;
  logic        nberr_reg, nberr_next;
  logic        ndoe_reg, ndoe_next;
  logic [15:0] dout_reg, dout_next;

  logic        wr_en, bell_set, ack_entry, release_all;
  logic        strobe_low, e_rise, e_fall, irq;
  logic [15:0] rd_data;
  win_t        win;

  assign strobe_low = !nuds_s_reg || !nlds_s_reg;
  assign e_rise     = e_edge(e_prev_reg, e_s_reg, 1'b1);
  assign e_fall     = e_edge(e_prev_reg, e_s_reg, 1'b0);
  assign win        = decode_window(a_s_reg, BASE, VBASE);

  iob_target_regs #(
    .ID_WORD (ID_WORD)
  ) u_regs (
    .clk      (CLK_IOB),
    .srst     (RES),
    .addr     (a_s_reg[3:1]),
    .wr_en    (wr_en),
    .lane_en  ({!nuds_s_reg, !nlds_s_reg}),
    .wr_data  (din_s_reg),
    .rd_data  (rd_data),
    .bell_set (bell_set),
    .irq_clr  (IRQ_CLR),
    .irq      (irq)
  );

  // A bus cycle caught mid-way by reset is sat out in IGNORE.
  always_ff @(posedge CLK_IOB) begin
    if (RES) begin
      state_reg  <= nAS_IOB ? ST_IDLE : ST_IGNORE;
      cnt_reg    <= '0;
      ndtack_reg <= 1'b1;
      nvpa_reg   <= 1'b1;
      nberr_reg  <= 1'b1;
      ndoe_reg   <= 1'b1;
      dout_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ndtack_reg <= ndtack_next;
      nvpa_reg   <= nvpa_next;
      nberr_reg  <= nberr_next;
      ndoe_reg   <= ndoe_next;
      dout_reg   <= dout_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    ndtack_next = ndtack_reg;
    nvpa_next   = nvpa_reg;
    nberr_next  = nberr_reg;
    ndoe_next   = ndoe_reg;
    dout_next   = dout_reg;
    wr_en       = 1'b0;
    bell_set    = 1'b0;
    ack_entry   = 1'b0;
    release_all = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!nas_s_reg) begin
          unique case (win)
            WIN_MBX:  state_next = ST_STROBE;
            WIN_BERR: begin
              state_next = ST_ERR;
              nberr_next = 1'b0;
            end
            WIN_VPA: begin
              state_next = ST_VWAIT;
              nvpa_next  = 1'b0;
            end
            WIN_IGNORE: state_next = ST_IGNORE;
          endcase
        end
      end
      ST_STROBE: begin
        if (nas_s_reg) begin
          release_all = 1'b1;
        end else if (strobe_low) begin
          if (WAIT_INIT == 3'd0) begin
            ack_entry = 1'b1;
          end else begin
            cnt_next   = WAIT_INIT;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (nas_s_reg)            release_all = 1'b1;
        else if (cnt_reg <= 3'd1) ack_entry   = 1'b1;
        else                      cnt_next    = cnt_reg - 3'd1;
      end
      ST_ACK: state_next = ST_HOLD;
      ST_VWAIT: begin
        if (nas_s_reg) begin
          release_all = 1'b1;
        end else if (!nvma_s_reg && e_rise) begin
          state_next = ST_VXFER;
          if (nwe_s_reg) begin
            ndoe_next = 1'b0;
            dout_next = {15'b0, irq};
          end
        end
      end
      ST_VXFER: begin
        if (nas_s_reg) begin
          release_all = 1'b1;
        end else begin
          if (nwe_s_reg) begin
            ndoe_next = 1'b0;
            dout_next = {15'b0, irq};
          end
          // Doorbell data is taken at the end of the E-high phase.
          if (e_fall) begin
            state_next = ST_HOLD;
            bell_set   = !nwe_s_reg && din_s_reg[0];
          end
        end
      end
      ST_ERR:    state_next = ST_HOLD;
      ST_HOLD:   if (nas_s_reg) release_all = 1'b1;
      ST_IGNORE: if (nas_s_reg) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase

    if (ack_entry) begin
      state_next  = ST_ACK;
      ndtack_next = 1'b0;
      if (nwe_s_reg) begin
        ndoe_next = 1'b0;
        dout_next = rd_data;
      end else begin
        wr_en = 1'b1;
      end
    end

    if (release_all) begin
      state_next  = ST_IDLE;
      ndtack_next = 1'b1;
      nvpa_next   = 1'b1;
      nberr_next  = 1'b1;
      ndoe_next   = 1'b1;
      dout_next   = '0;
    end
  end

  assign DOUT_IOB   = dout_reg;
  assign nDOE_IOB   = ndoe_reg;
  assign nDTACK_IOB = ndtack_reg;
  assign nVPA_IOB   = nvpa_reg;
  assign nBERR_IOB  = nberr_reg;
  assign IRQ        = irq;

endmodule

// File: doc/iob_target.md
# iob_target

Synchronous 68000-protocol bus responder on the IOB (PDS) side of the accelerator. It answers cycles driven by an IOB initiator and supports two cycle types:
- asynchronous nDTACK-terminated cycles into an 8-word mailbox register file;
- E-clock-synchronous nVPA/nVMA cycles into a single doorbell register.

It is the target-end counterpart of the IOB master and serves as the card-resident register window visible to the host Mac.

## Interface
Parameters:
- BASE, 16'hF8F0: A_IOB[23:8] match for the nDTACK mailbox window (256 bytes).
- VBASE, 16'hF8F1: A_IOB[23:8] match for the nVPA doorbell window.
- WAIT_CYCLES, 2: CLK_IOB cycles from data strobe sampled low to nDTACK low (0–7).
- ID_WORD, 16'h5E30: read-only value of mailbox word 0.

Ports:
- CLK_IOB  in  1  IOB bus clock; all logic on its rising edge.
- RES  in  1  reset, synchronous, active-high.
- A_IOB  in  23  address [23:1].
- nAS_IOB, nUDS_IOB, nLDS_IOB, nWE_IOB, nVMA_IOB  in  1 each  initiator strobes.
- E_IOB  in  1  E clock.
- DIN_IOB  in  16  data from bus.
- DOUT_IOB  out  16  read data.
- nDOE_IOB  out  1  read-data drive enable, active low.
- nDTACK_IOB, nVPA_IOB, nBERR_IOB  out  1 each  termination; a high level means released.
- IRQ  out  1  doorbell pending, to the local side.
- IRQ_CLR  in  1  local-side clear of IRQ, single-cycle pulse.

## Operation
- Inputs are registered once on CLK_IOB and used as the "sampled" values; no further synchronization is applied because the initiator is synchronous to CLK_IOB.
- Window decode, performed in IDLE on the first cycle nAS is sampled low:
  - A[23:8]==BASE and A[7:1]<8 → MBX.
  - A[23:8]==BASE and A[7:1]≥8 → BERR.
  - A[23:8]==VBASE → VPA.
  - Anything else → IGNORE; all outputs stay released.
- States: IDLE, STROBE, WAIT, ACK, VWAIT, VXFER, ERR, HOLD, IGNORE.
- IDLE → STROBE (MBX) / ERR / VWAIT / IGNORE according to the decode.
- STROBE: wait until either data strobe is sampled low, then load the wait counter with WAIT_CYCLES and go to WAIT. If WAIT_CYCLES=0, go directly to ACK.
- WAIT: decrement the counter; at 0 go to ACK.
- ACK:
  - Drive nDTACK low.
  - Reads: drive nDOE low with DOUT = reg[A[3:1]].
  - Writes: on ACK entry, write each byte lane whose strobe is low (UDS → [15:8], LDS → [7:0]) into words 1–6. Writes to word 0 or word 7 are discarded. Word 7 reads back {15'b0, IRQ}.
  - Go to HOLD.
- VWAIT:
  - Drive nVPA low.
  - Wait for nVMA sampled low AND an E rising edge (E sampled 0 then 1), then go to VXFER.
- VXFER:
  - Reads: drive DOUT = {15'b0, IRQ} with nDOE low.
  - Writes: latch DIN[0] as the doorbell. A value of 1 sets IRQ; 0 has no effect.
  - On an E falling edge, go to HOLD.
- ERR: drive nBERR low; go to HOLD.
- HOLD:
  - Keep whichever termination is asserted, and keep nDOE and DOUT, until nAS is sampled high.
  - On the cycle nAS is sampled high, release everything and go to IDLE.
- IGNORE: wait for nAS sampled high, then go to IDLE.
- IRQ priority: IRQ_CLR beats a same-cycle doorbell set. The clear wins; the set is lost.
- Reset:
  - All outputs are released: nDTACK=nVPA=nBERR=nDOE=1, DOUT=0, IRQ=0.
  - Words 1–6 are cleared and the state returns to IDLE.
  - If nAS is still sampled low when reset deasserts, the block enters IGNORE, never a partial cycle.
- Only one of nDTACK, nVPA or nBERR is ever asserted at a time.

## Timing
- Cycle start: first edge with nAS sampled low. Decode completes on the next edge.
- nDTACK falls exactly WAIT_CYCLES+1 edges after the edge on which a strobe is first sampled low.
- nVPA falls 1 edge after nAS is sampled low. The transfer spans the E-high phase with nVMA low.
- Release latency: all terminations and nDOE go high 1 edge after nAS is sampled high.
- Back-to-back: a new cycle can be decoded on the edge following the return to IDLE. nAS must be sampled high for at least 1 cycle between cycles.
- Strobe deassertion without nAS deassertion does not end a cycle.

## Structure
- Shared package:
  - state enum;
  - window-kind enum {MBX, VPA, BERR, IGNORE};
  - register-index constants ID=0, DBELL=7;
  - the E-edge detect helper.
- One sub-module, iob_target_regs: the 8×16 register file with byte-lane write enables, word-0/word-7 read muxing, and IRQ set/clear logic.

## Test plan
- Word write then read: write 16'hA55A to BASE+2 with both strobes and WAIT_CYCLES=2 → nDTACK low 3 edges after strobe. Then read BASE+2 → DOUT=16'hA55A, nDOE low in ACK/HOLD.
- Byte lane: write 16'h1234 with only nLDS low to word 3 (reset contents 0) → readback 16'h0034.
- Read-only words: read BASE+0 → 16'h5E30. Write 16'hFFFF to word 0 → readback still 16'h5E30.
- Bad offset: access BASE+16 (word 8) → nBERR low; nDTACK and nVPA stay high; release 1 edge after nAS high.
- VPA doorbell: write 1 to VBASE with nVMA low across an E cycle → nVPA low throughout, IRQ=1 after the E falling edge. VPA read → DOUT=16'h0001. IRQ_CLR in the same cycle as a second doorbell → IRQ=0.
- Reset mid-cycle: assert RES during WAIT with nAS still low → all outputs high next edge, no nDTACK while nAS stays low; the next full cycle completes normally.
